interrupt_ctrl: RTL and testbench
=================================

Name: interrupt_ctrl

Overview:
Parametrised interrupt controller with NUM_CH channels. It holds the IF (flag) and IE (enable) registers internally, CPU-mapped at IF_ADDR and IE_ADDR. It selects the highest-priority pending and enabled channel, presents a request and vector to the CPU core, and completes an acknowledge handshake that clears the serviced flag. It sits between the peripheral interrupt sources (PPU, timer, serial, joypad, ...) and the CPU core.

Parameters:
NUM_CH, 5, number of interrupt channels (1..8); channel 0 has the highest priority.
VEC_BASE, 16'h0040, vector address of channel 0.
VEC_STRIDE, 8, vector spacing between consecutive channels.
IF_ADDR, 16'hFF0F, CPU address of the IF register.
IE_ADDR, 16'hFFFF, CPU address of the IE register.

Ports:
I_CLOCK  input  1  system clock; all state changes on the rising edge.
I_RESET_L  input  1  asynchronous, active-low reset.
I_IRQ  input  NUM_CH  interrupt source lines, one per channel.
I_CPU_ADDR  input  16  CPU bus address.
I_CPU_WDATA  input  8  CPU write data.
I_MEM_WE_L  input  1  active-low write strobe; one write per cycle while low.
I_MEM_RE_L  input  1  active-low read strobe.
O_CPU_RDATA  output  8  read data; 8'h00 when no register is selected.
O_RD_HIT  output  1  high when a read targets IF_ADDR or IE_ADDR.
I_IME  input  1  CPU master interrupt enable.
O_INT_REQ  output  1  interrupt request to the CPU.
O_INT_VECTOR  output  16  vector of the selected channel.
I_INT_ACK  input  1  one-cycle acknowledge from the CPU.
O_ACK  output  NUM_CH  one-hot, one-cycle pulse naming the serviced channel.
O_WAKE  output  1  high when (IF & IE) != 0, independent of I_IME; drives HALT exit.

Behaviour:
- Reset (async assert, sync release): IF=0, IE=0, edge-history register=0, FSM=IDLE, O_INT_REQ=0, O_ACK=0.
- pend = IF & IE. sel = lowest set index of pend.
- O_INT_VECTOR = VEC_BASE + sel*VEC_STRIDE, truncated to 16 bits. When pend=0 it equals VEC_BASE. Combinational.
- O_WAKE = |pend, combinational.
- Source capture (see Optional Feature): set_mask bits are computed from I_IRQ each cycle.
- IF next-state, per bit: IF_n = (wr_if ? I_CPU_WDATA[i] : IF[i]) & ~clr[i] | set_mask[i].
  - Priority order: source set > ack clear > CPU write.
- IE next-state: I_CPU_WDATA[NUM_CH-1:0] when a write hits IE_ADDR; otherwise unchanged.
- Write decode: wr_if = ~I_MEM_WE_L && I_CPU_ADDR==IF_ADDR. wr_ie is decoded the same way against IE_ADDR.
- Reads are combinational, same cycle:
  - IF read returns {1s in bits 7..NUM_CH, IF}.
  - IE read returns {0s in bits 7..NUM_CH, IE}.
  - O_RD_HIT = ~I_MEM_RE_L && address matches either register.
- FSM states IDLE, PEND, SERVICE:
  - IDLE: O_INT_REQ=0. Go to PEND when I_IME && |pend.
  - PEND: O_INT_REQ=1.
    - If !(I_IME && |pend), return to IDLE; the request is withdrawn with no ack.
    - Else if I_INT_ACK: latch sel, set clr = one-hot(sel) in this same cycle, go to SERVICE.
  - SERVICE: O_INT_REQ=0. O_ACK = one-hot(latched sel) for exactly this one cycle. Go to IDLE unconditionally.
- Request timing: minimum latency from the IF bit set to O_INT_REQ high is 1 cycle (IF registered, then FSM). After SERVICE, a further pending interrupt re-requests no earlier than 2 cycles later.
- Boundary conditions:
  - I_INT_ACK in IDLE or SERVICE is ignored.
  - Ack in the same cycle as a CPU write to IF: the selected bit is cleared; other bits take the written value.
  - Source set in the same cycle as an ack of the same channel: IF bit stays 1; the channel re-requests later.
  - Simultaneous sources are all captured; lowest index is served first.
  - Reset asserted mid-PEND or mid-SERVICE: immediate return to reset state; no O_ACK pulse.
  - Bits of I_CPU_WDATA above NUM_CH-1 are ignored.

Optional Feature:
- Macro INTC_EDGE_DETECT_EN.
- Defined:
  - Each I_IRQ bit is registered into the edge-history register.
  - set_mask = I_IRQ & ~history, so only a rising edge sets IF.
  - A held-high source sets IF once.
- Undefined:
  - No history register; set_mask = I_IRQ.
  - A held-high source re-sets IF every cycle, so a CPU clear or an ack does not stick while the source is high.
  - Sources must pulse for one cycle.

Test Plan:
- Reset with all I_IRQ=0. Write IE=8'h1F, then pulse I_IRQ[2] for 1 cycle with I_IME=1. Expect: O_WAKE high; O_INT_REQ high 1 cycle after IF sets; O_INT_VECTOR=16'h0050. Ack: O_ACK=5'b00100 next cycle; read of IF returns 8'hE0.
- Pulse I_IRQ[4] and I_IRQ[1] together with IE=8'h1F. Expect: vector 16'h0048 served first; after its SERVICE, re-request with 16'h0060.
- With I_IME=0, set IF[0] with IE[0]=1. Expect: O_WAKE=1, O_INT_REQ stays 0. Then raise I_IME: request appears 1 cycle later.
- In PEND, the CPU writes IF=0 in the same cycle as no ack. Expect: return to IDLE; O_INT_REQ drops; no O_ACK pulse.
- In PEND on channel 3 (16'h0058), assert I_INT_ACK together with an I_IRQ[3] edge. Expect: O_ACK[3] pulse; IF[3] remains 1; re-request after 2 cycles.
- With INTC_EDGE_DETECT_EN defined, hold I_IRQ[0] high 10 cycles and ack once. Expect: exactly one O_ACK[0], and IF[0]=0 afterwards. With the macro undefined, IF[0] reads 1 while the source is held.

Source files
------------

// File: rtl/interrupt_ctrl_if.sv
// CPU-side bus and interrupt handshake bundle for interrupt_ctrl.
// The master modport is the CPU core, and the slave modport is the controller.
interface interrupt_ctrl_if #(
    parameter int NUM_CH = 5
);
    logic [15:0]       I_CPU_ADDR;
    logic [7:0]        I_CPU_WDATA;
    logic              I_MEM_WE_L;
    logic              I_MEM_RE_L;
    logic [7:0]        O_CPU_RDATA;
    logic              O_RD_HIT;
    logic              I_IME;
    logic              O_INT_REQ;
    logic [15:0]       O_INT_VECTOR;
    logic              I_INT_ACK;
    logic [NUM_CH-1:0] O_ACK;
    logic              O_WAKE;

    modport master (
        output I_CPU_ADDR, I_CPU_WDATA, I_MEM_WE_L, I_MEM_RE_L, I_IME, I_INT_ACK,
        input  O_CPU_RDATA, O_RD_HIT, O_INT_REQ, O_INT_VECTOR, O_ACK, O_WAKE
    );

    modport slave (
        input  I_CPU_ADDR, I_CPU_WDATA, I_MEM_WE_L, I_MEM_RE_L, I_IME, I_INT_ACK,
        output O_CPU_RDATA, O_RD_HIT, O_INT_REQ, O_INT_VECTOR, O_ACK, O_WAKE
    );
endinterface

// File: rtl/interrupt_ctrl.sv
// Priority interrupt controller with CPU-mapped IF/IE registers and request/ack FSM; request 1 cycle after IF sets.
// Define INTC_EDGE_DETECT_EN to set IF only on rising source edges (default: level, sources pulse 1 cycle).
module interrupt_ctrl #(
    parameter int          NUM_CH     = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter logic [15:0] VEC_STRIDE = 16'd8,
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET_L,
    input  logic [NUM_CH-1:0]  I_IRQ,
    interrupt_ctrl_if.slave    bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PEND    = 2'd1;
    localparam logic [1:0] S_SERVICE = 2'd2;

    logic [NUM_CH-1:0] r_if;
    logic [NUM_CH-1:0] r_ie;
    logic [NUM_CH-1:0] r_ack_oh;
    logic [1:0]        r_state;

    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_sel_oh;
    logic [NUM_CH-1:0] w_set;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_if_nx;
    logic [2:0]        w_sel;
    logic [1:0]        w_state_nx;
    logic              w_req_ok;
    logic              w_wr_if;
    logic              w_wr_ie;
    logic              w_rd_if;
    logic              w_rd_ie;
    logic [7:0]        w_if_rd;
    logic [7:0]        w_ie_rd;

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_CH-1:0] r_hist;

    always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
        if (!I_RESET_L) r_hist <= '0;
        else            r_hist <= I_IRQ;
    end

    assign w_set = I_IRQ & ~r_hist;
`else
    assign w_set = I_IRQ;
`endif

    assign w_pend   = r_if & r_ie;
    assign w_sel_oh = w_pend & (~w_pend + 1'b1);
    assign w_req_ok = bus.I_IME && (|w_pend);

    // Scan from the top so the lowest pending index wins.
    always_comb begin
        w_sel = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_pend[i]) w_sel = 3'(i);
        end
    end

    assign bus.O_INT_VECTOR = VEC_BASE + ({13'd0, w_sel} * VEC_STRIDE);
    assign bus.O_WAKE       = |w_pend;

    assign w_wr_if = ~bus.I_MEM_WE_L && (bus.I_CPU_ADDR == IF_ADDR);
    assign w_wr_ie = ~bus.I_MEM_WE_L && (bus.I_CPU_ADDR == IE_ADDR);
    assign w_rd_if = ~bus.I_MEM_RE_L && (bus.I_CPU_ADDR == IF_ADDR);
    assign w_rd_ie = ~bus.I_MEM_RE_L && (bus.I_CPU_ADDR == IE_ADDR);

    always_comb begin
        w_if_rd = 8'hFF;
        w_ie_rd = 8'h00;
        for (int i = 0; i < NUM_CH; i++) begin
            w_if_rd[i] = r_if[i];
            w_ie_rd[i] = r_ie[i];
        end
    end

    assign bus.O_RD_HIT    = w_rd_if || w_rd_ie;
    assign bus.O_CPU_RDATA = w_rd_if ? w_if_rd : (w_rd_ie ? w_ie_rd : 8'h00);

    always_comb begin
        w_state_nx = r_state;
        w_clr      = '0;
        case (r_state)
            S_IDLE: begin
                if (w_req_ok) w_state_nx = S_PEND;
            end
            S_PEND: begin
                if (!w_req_ok) begin
                    w_state_nx = S_IDLE;
                end else if (bus.I_INT_ACK) begin
                    w_clr      = w_sel_oh;
                    w_state_nx = S_SERVICE;
                end
            end
            S_SERVICE: w_state_nx = S_IDLE;
            default:   w_state_nx = S_IDLE;
        endcase
    end

    // Source set beats ack clear, which beats the CPU write.
    always_comb begin
        w_if_nx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_if_nx[i] = ((w_wr_if ? bus.I_CPU_WDATA[i] : r_if[i]) & ~w_clr[i]) | w_set[i];
        end
    end

    always_ff @(posedge I_CLOCK or negedge I_RESET_L) begin
        if (!I_RESET_L) begin
            r_if     <= '0;
            r_ie     <= '0;
            r_state  <= S_IDLE;
            r_ack_oh <= '0;
        end else begin
            r_if     <= w_if_nx;
            r_state  <= w_state_nx;
            r_ack_oh <= w_clr;
            if (w_wr_ie) r_ie <= bus.I_CPU_WDATA[NUM_CH-1:0];
        end
    end

    // w_clr is non-zero only on the PEND->SERVICE edge, so this is a one-cycle pulse in SERVICE.
    assign bus.O_ACK     = r_ack_oh;
    assign bus.O_INT_REQ = (r_state == S_PEND);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: expectations queued at stimulus time, popped at sample time.
module tb_interrupt_ctrl;
    localparam int          NUM_CH = 5;
    localparam logic [15:0] A_IF   = 16'hFF0F;
    localparam logic [15:0] A_IE   = 16'hFFFF;

    logic              I_CLOCK;
    logic              I_RESET_L;
    logic [NUM_CH-1:0] I_IRQ;

    interrupt_ctrl_if #(.NUM_CH(NUM_CH)) bus ();

    interrupt_ctrl #(.NUM_CH(NUM_CH)) dut (
        .I_CLOCK   (I_CLOCK),
        .I_RESET_L (I_RESET_L),
        .I_IRQ     (I_IRQ),
        .bus       (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic observe(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_underflow observed=%h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        bus.I_CPU_ADDR  = a;
        bus.I_CPU_WDATA = d;
        bus.I_MEM_WE_L  = 1'b0;
        tick();
        bus.I_MEM_WE_L  = 1'b1;
    endtask

    task automatic cpu_rd(input logic [15:0] a, output logic [7:0] d, output logic hit);
        bus.I_CPU_ADDR = a;
        bus.I_MEM_RE_L = 1'b0;
        #1;
        d   = bus.O_CPU_RDATA;
        hit = bus.O_RD_HIT;
        bus.I_MEM_RE_L = 1'b1;
    endtask

    logic [7:0] rd;
    logic       hit;
    int         ack_cnt;
    int         wait_n;

    initial begin
        I_RESET_L       = 1'b0;
        I_IRQ           = '0;
        bus.I_CPU_ADDR  = 16'h0000;
        bus.I_CPU_WDATA = 8'h00;
        bus.I_MEM_WE_L  = 1'b1;
        bus.I_MEM_RE_L  = 1'b1;
        bus.I_IME       = 1'b0;
        bus.I_INT_ACK   = 1'b0;

        // Reset state
        #2;
        expect_val("rst_req", 0);           observe(32'(bus.O_INT_REQ));
        expect_val("rst_ack", 0);           observe(32'(bus.O_ACK));
        expect_val("rst_wake", 0);          observe(32'(bus.O_WAKE));
        expect_val("rst_vec", 32'h0040);    observe(32'(bus.O_INT_VECTOR));
        cpu_rd(A_IF, rd, hit);
        expect_val("rst_if_rd", 32'hE0);    observe(32'(rd));
        expect_val("rst_if_hit", 1);        observe(32'(hit));
        cpu_rd(16'h1234, rd, hit);
        expect_val("miss_rd", 0);           observe(32'(rd));
        expect_val("miss_hit", 0);          observe(32'(hit));
        tick();
        I_RESET_L = 1'b1;
        tick();

        // IE upper bits ignored, then enable all channels
        cpu_wr(A_IE, 8'hFF);
        cpu_rd(A_IE, rd, hit);
        expect_val("ie_mask_rd", 32'h1F);   observe(32'(rd));
        cpu_wr(A_IE, 8'h00);
        cpu_rd(A_IE, rd, hit);
        expect_val("ie_zero_rd", 32'h00);   observe(32'(rd));
        cpu_wr(A_IE, 8'h1F);
        bus.I_IME = 1'b1;

        // Single channel 2
        I_IRQ = 5'b00100;
        tick();
        I_IRQ = '0;
        expect_val("c2_wake", 1);           observe(32'(bus.O_WAKE));
        expect_val("c2_req_early", 0);      observe(32'(bus.O_INT_REQ));
        expect_val("c2_vec", 32'h0050);     observe(32'(bus.O_INT_VECTOR));
        cpu_rd(A_IF, rd, hit);
        expect_val("c2_if_rd", 32'hE4);     observe(32'(rd));
        tick();
        expect_val("c2_req", 1);            observe(32'(bus.O_INT_REQ));
        bus.I_INT_ACK = 1'b1;
        tick();
        bus.I_INT_ACK = 1'b0;
        expect_val("c2_ack", 32'h04);       observe(32'(bus.O_ACK));
        expect_val("c2_req_svc", 0);        observe(32'(bus.O_INT_REQ));
        cpu_rd(A_IF, rd, hit);
        expect_val("c2_if_clr", 32'hE0);    observe(32'(rd));
        tick();
        expect_val("c2_ack_end", 0);        observe(32'(bus.O_ACK));

        // Ack while IDLE is ignored
        bus.I_INT_ACK = 1'b1;
        tick();
        bus.I_INT_ACK = 1'b0;
        expect_val("idle_ack_ign", 0);      observe(32'(bus.O_ACK));

        // Simultaneous channels 4 and 1
        I_IRQ = 5'b10010;
        tick();
        I_IRQ = '0;
        expect_val("c41_vec1", 32'h0048);   observe(32'(bus.O_INT_VECTOR));
        tick();
        expect_val("c41_req1", 1);          observe(32'(bus.O_INT_REQ));
        bus.I_INT_ACK = 1'b1;
        tick();
        bus.I_INT_ACK = 1'b0;
        expect_val("c41_ack1", 32'h02);     observe(32'(bus.O_ACK));
        expect_val("c41_vec2", 32'h0060);   observe(32'(bus.O_INT_VECTOR));
        tick();
        expect_val("c41_gap", 0);           observe(32'(bus.O_INT_REQ));
        tick();
        expect_val("c41_req2", 1);          observe(32'(bus.O_INT_REQ));
        bus.I_INT_ACK = 1'b1;
        tick();
        bus.I_INT_ACK = 1'b0;
        expect_val("c41_ack2", 32'h10);     observe(32'(bus.O_ACK));
        tick();

        // IME gating
        bus.I_IME = 1'b0;
        I_IRQ = 5'b00001;
        tick();
        I_IRQ = '0;
        expect_val("ime0_wake", 1);         observe(32'(bus.O_WAKE));
        tick();
        tick();
        expect_val("ime0_req", 0);          observe(32'(bus.O_INT_REQ));
        bus.I_IME = 1'b1;
        tick();
        expect_val("ime1_req", 1);          observe(32'(bus.O_INT_REQ));

        // CPU clears IF while PEND: request withdrawn, no ack
        cpu_wr(A_IF, 8'h00);
        expect_val("wd_ack0", 0);           observe(32'(bus.O_ACK));
        tick();
        expect_val("wd_req", 0);            observe(32'(bus.O_INT_REQ));
        expect_val("wd_ack1", 0);           observe(32'(bus.O_ACK));
        cpu_rd(A_IF, rd, hit);
        expect_val("wd_if_rd", 32'hE0);     observe(32'(rd));

        // Ack collides with a new edge on the same channel 3
        I_IRQ = 5'b01000;
        tick();
        I_IRQ = '0;
        tick();
        expect_val("c3_req", 1);            observe(32'(bus.O_INT_REQ));
        expect_val("c3_vec", 32'h0058);     observe(32'(bus.O_INT_VECTOR));
        bus.I_INT_ACK = 1'b1;
        I_IRQ = 5'b01000;
        tick();
        bus.I_INT_ACK = 1'b0;
        I_IRQ = '0;
        expect_val("c3_ack", 32'h08);       observe(32'(bus.O_ACK));
        cpu_rd(A_IF, rd, hit);
        expect_val("c3_if_kept", 32'hE8);   observe(32'(rd));
        tick();
        expect_val("c3_gap", 0);            observe(32'(bus.O_INT_REQ));
        tick();
        expect_val("c3_rereq", 1);          observe(32'(bus.O_INT_REQ));
        bus.I_INT_ACK = 1'b1;
        tick();
        bus.I_INT_ACK = 1'b0;
        expect_val("c3_ack2", 32'h08);      observe(32'(bus.O_ACK));
        tick();

        // Held source on channel 0 with a single ack
        ack_cnt = 0;
        I_IRQ = 5'b00001;
        for (int i = 0; i < 10; i++) begin
            bus.I_INT_ACK = (i == 2);
            tick();
            if (bus.O_ACK == 5'b00001) ack_cnt++;
        end
        bus.I_INT_ACK = 1'b0;
        expect_val("hold_ack_cnt", 1);      observe(32'(ack_cnt));
        cpu_rd(A_IF, rd, hit);
`ifdef INTC_EDGE_DETECT_EN
        expect_val("hold_if_edge", 32'hE0); observe(32'(rd));
`else
        expect_val("hold_if_lvl", 32'hE1);  observe(32'(rd));
        cpu_wr(A_IF, 8'h00);
        cpu_rd(A_IF, rd, hit);
        expect_val("hold_wr_lost", 32'hE1); observe(32'(rd));
`endif
        I_IRQ = '0;
        tick();

        // Reset asserted while PEND
        I_IRQ = 5'b00001;
        tick();
        I_IRQ = '0;
        wait_n = 0;
        while (!bus.O_INT_REQ && wait_n < 10) begin
            tick();
            wait_n++;
        end
        expect_val("pre_rst_req", 1);       observe(32'(bus.O_INT_REQ));
        #2;
        I_RESET_L = 1'b0;
        #1;
        expect_val("mid_rst_req", 0);       observe(32'(bus.O_INT_REQ));
        expect_val("mid_rst_ack", 0);       observe(32'(bus.O_ACK));
        expect_val("mid_rst_wake", 0);      observe(32'(bus.O_WAKE));
        cpu_rd(A_IE, rd, hit);
        expect_val("mid_rst_ie", 32'h00);   observe(32'(rd));
        tick();
        expect_val("mid_rst_ack2", 0);      observe(32'(bus.O_ACK));

        checks++;
        assert (exp_q.size() == 0) else begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
